// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes one seven-segment decoder across NUM_DIGITS digits with tear-free double buffering
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    off,
  input  logic [2:0]              err,
  input  logic                    lzb_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    ready,
  output logic [3:0]              digit_code,
  output logic                    drv_start,
  output logic                    drv_off,
  output logic [2:0]              drv_err,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, ns;
  logic [IW-1:0] idx, nidx;
  logic [CW-1:0] cnt, ncnt;
  logic [4*NUM_DIGITS-1:0] active, shadow;
  logic pending, go, slot_end, boundary, lit, zero_run;
  logic [NUM_DIGITS-1:0] blank_mask;
  assign ready = !pending;
  // slot sequencing: blank gap then show, advancing digit at each slot end; abort to IDLE whenever not running
  always_comb begin
    go = start && !off;
    slot_end = state == SHOW && cnt == CW'(REFRESH_DIV - 1);
    boundary = go && slot_end && idx == IW'(NUM_DIGITS - 1);
    ns = state;
    nidx = idx;
    ncnt = cnt;
    if (!go) begin
      ns = IDLE;
      nidx = '0;
      ncnt = '0;
    end else if (state == IDLE) begin
      ns = BLANK;
      nidx = '0;
      ncnt = '0;
    end else if (slot_end) begin
      ns = BLANK;
      nidx = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      ncnt = '0;
    end else begin
      ncnt = cnt + 1'b1;
      ns = (state == BLANK && cnt == CW'(BLANK_CYCLES - 1)) ? SHOW : state;
    end
  end
  // a digit above 0 is blanked when it and every more significant nibble are zero
  always_comb begin
    zero_run = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && active[4*i +: 4] == 4'd0;
      blank_mask[i] = zero_run && lzb_en && err == 3'd0;
    end
  end
  assign lit = ns == SHOW && !blank_mask[nidx];
  // scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= ns;
      idx <= nidx;
      cnt <= ncnt;
    end
  end
  // double buffer: accept into shadow, promote to active only in IDLE or at a frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
      shadow <= '0;
      pending <= 1'b0;
    end else if (load && !pending) begin
      shadow <= value;
      pending <= 1'b1;
    end else if (pending && (state == IDLE || boundary)) begin
      active <= shadow;
      pending <= 1'b0;
    end
  end
  // outputs registered from next-state so anode, code and off change on the same edge as the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an <= '1;
      digit_code <= '0;
      drv_off <= 1'b1;
      drv_start <= 1'b0;
      drv_err <= '0;
      frame_tick <= 1'b0;
    end else begin
      an <= lit ? ~(NUM_DIGITS'(1) << nidx) : '1;
      digit_code <= ns == SHOW ? active[4*nidx +: 4] : 4'd0;
      drv_off <= !lit;
      drv_start <= ns != IDLE;
      drv_err <= err;
      frame_tick <= boundary;
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard bench against a time-based reference model of the scan controller
module tb_display_scan_controller;
  localparam int ND = 4, RD = 8, BC = 2, FRAME = ND * RD;
  logic clk = 0, rst, start, off, lzb_en, load, ready, drv_start, drv_off, frame_tick;
  logic [2:0] err, drv_err;
  logic [15:0] value;
  logic [3:0] digit_code, an;
  int vecs = 0, errs = 0;
  logic [14:0] exp_q[$];
  int m_t, d;
  bit m_run, m_pend, old_p, go, tick, show, blk;
  logic [15:0] m_act, m_sh;
  logic [3:0] e_an, nib;

  display_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .off(off), .err(err), .lzb_en(lzb_en),
    .load(load), .value(value), .ready(ready), .digit_code(digit_code),
    .drv_start(drv_start), .drv_off(drv_off), .drv_err(drv_err), .an(an),
    .frame_tick(frame_tick));

  always #5 clk = ~clk;

  // reference model: running time t since start; digit = t/RD, phase = t%RD
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_t = 0; m_act = 0; m_sh = 0; m_pend = 0;
      exp_q.delete();
    end else begin
      go = start && !off;
      old_p = m_pend;
      tick = m_run && go && m_t == FRAME - 1;
      if (load && !old_p) begin m_sh = value; m_pend = 1; end
      if (old_p && (!m_run || tick)) begin m_act = m_sh; m_pend = 0; end
      if (!go) begin m_run = 0; m_t = 0; end
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t = (m_t + 1) % FRAME;
      d = m_t / RD;
      show = m_run && (m_t % RD) >= BC;
      blk = lzb_en && err == 0 && d > 0 && (m_act >> (4 * d)) == 0;
      nib = 4'((m_act >> (4 * d)) & 15);
      e_an = (show && !blk) ? 4'(~(1 << d)) : 4'hF;
      exp_q.push_back({e_an, show ? nib : 4'h0, !(show && !blk), m_run, err, tick, !m_pend});
    end
  end

  // monitor: compare DUT outputs against the oldest expectation each cycle
  always @(negedge clk) begin
    logic [14:0] e, a;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {an, digit_code, drv_off, drv_start, drv_err, frame_tick, ready};
      vecs++;
      if (a !== e) begin
        errs++;
        $display("FAIL out @%0t: got %h want %h (an,code,off,start,err,tick,ready)", $time, a, e);
      end
    end
  end

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic wait_an(input logic [3:0] p);
    int k = 0;
    while (an !== p && k < 200) begin @(negedge clk); k++; end
    chk("wait_an", 16'(an), 16'(p));
  endtask

  task automatic reset_checks();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_off", 16'(drv_off), 16'd1);
    chk("rst_ready", 16'(ready), 16'd1);
    chk("rst_start", 16'(drv_start), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    chk("rst_code", 16'(digit_code), 16'd0);
    chk("rst_err", 16'(drv_err), 16'd0);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load = 1; value = v; @(negedge clk); load = 0;
  endtask

  initial begin
    rst = 1; start = 0; off = 0; err = 0; lzb_en = 0; load = 0; value = 0;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 0;
    @(negedge clk);
    pulse_load(16'h1234);
    repeat (3) @(negedge clk);
    start = 1;
    repeat (40) @(negedge clk);
    pulse_load(16'hABCD);
    repeat (80) @(negedge clk);
    wait_an(4'b1011);
    #2 rst = 1;
    #1 reset_checks();
    @(negedge clk); @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    start = 0; lzb_en = 1;
    pulse_load(16'h0050);
    repeat (2) @(negedge clk);
    start = 1;
    repeat (70) @(negedge clk);
    start = 0;
    pulse_load(16'h0000);
    start = 1;
    repeat (70) @(negedge clk);
    start = 0; err = 3'b010;
    pulse_load(16'h0050);
    start = 1;
    repeat (70) @(negedge clk);
    err = 0; lzb_en = 0;
    pulse_load(16'h9876);
    repeat (40) @(negedge clk);
    wait_an(4'b1011);
    off = 1; @(negedge clk); off = 0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 99) != 0;
      off = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 49) == 0) err = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
      if ($urandom_range(0, 99) == 0) lzb_en = 1'($urandom);
      load = $urandom_range(0, 9) == 0;
      for (int j = 0; j < 4; j++) value[4*j +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom);
      @(negedge clk);
    end
    load = 0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
